// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions: opcode constants, channel field widths and the
// routing target type used by the address decoder and its tracker.
package tl_ul_pkg;

   // Channel field widths
   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned PARAM_W  = 3;
   localparam int unsigned SIZE_W   = 2;
   localparam int unsigned MASK_W   = 4;
   localparam int unsigned DATA_W   = 32;

   // Outstanding-count width; covers MAX_OUT up to 15
   localparam int unsigned CNT_W = 4;

   // A-channel opcodes
   localparam logic [OPCODE_W-1:0] PutFull    = 3'd0;
   localparam logic [OPCODE_W-1:0] PutPartial = 3'd1;
   localparam logic [OPCODE_W-1:0] Get        = 3'd4;

   // D-channel opcodes
   localparam logic [OPCODE_W-1:0] AccessAck     = 3'd0;
   localparam logic [OPCODE_W-1:0] AccessAckData = 3'd1;

   // Downstream port a request is routed to
   typedef enum logic {
      TgtDev = 1'b0,
      TgtErr = 1'b1
   } tgt_e;

endpackage

// File: rtl/tl_addr_decode_tracker.sv
// Outstanding-request tracker for tl_addr_decode.
// Holds the outstanding count and the target currently owning the in-flight
// requests, and decides whether a new A beat may be issued.
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   dec_tgt         - decoded target of the current A beat
//   a_fire, d_fire  - host A / host D handshakes this cycle
//   cnt, tgt        - outstanding count and owning target
//   allow           - current A beat may be issued
//   busy            - at least one request outstanding
module tl_addr_decode_tracker
   import tl_ul_pkg::*;
#(
   parameter int unsigned MAX_OUT = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  tgt_e             dec_tgt,
   input  logic             a_fire,
   input  logic             d_fire,
   output logic [CNT_W-1:0] cnt,
   output tgt_e             tgt,
   output logic             allow,
   output logic             busy
);

   localparam logic [CNT_W-1:0] MaxCnt = MAX_OUT[CNT_W-1:0];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   tgt_e             tgt_q, tgt_d;

   assign busy = (cnt_q != '0);

   // A target switch is only possible once every earlier response is back,
   // which keeps responses in request order across the two ports.
   assign allow = (cnt_q < MaxCnt) && (!busy || (tgt_q == dec_tgt));

   always_comb begin
      cnt_d = cnt_q;
      tgt_d = tgt_q;
      unique case ({a_fire, d_fire})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (a_fire && !busy) begin
         tgt_d = dec_tgt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tgt_q <= TgtDev;
      end else begin
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
      end
   end

   assign cnt = cnt_q;
   assign tgt = tgt_q;

endmodule

// File: rtl/tl_addr_decode.sv
// TL-UL address decoder: routes host A beats to the device when the address
// falls in the device region, otherwise to an error responder, and returns
// D beats from whichever port owns the outstanding requests.
// Optional feature macro: TL_ADDR_DECODE_ERR_LOG_EN enables a sticky log of
// the first decode-miss address; without it the log outputs read 0.
// Ports:
//   clock, reset_n     - clock, asynchronous active-low reset
//   h_a_* / h_d_*      - host A (in) and D (out) channels
//   dev_a_* / dev_d_*  - device A (out) and D (in) channels
//   err_a_* / err_d_*  - error responder A (out) and D (in) channels
//   err_log_valid/addr - sticky miss flag and first miss address
//   err_log_clr        - clears the miss log
module tl_addr_decode
   import tl_ul_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 14,
   parameter int unsigned       SRC_W    = 4,
   parameter int unsigned       MAX_OUT  = 4,
   parameter logic [ADDR_W-1:0] DEV_BASE = 14'h0000,
   parameter logic [ADDR_W-1:0] DEV_MASK = 14'h2000
) (
   input  logic                clock,
   input  logic                reset_n,
   // Host A
   input  logic                h_a_valid,
   output logic                h_a_ready,
   input  logic [OPCODE_W-1:0] h_a_opcode,
   input  logic [PARAM_W-1:0]  h_a_param,
   input  logic [SIZE_W-1:0]   h_a_size,
   input  logic [SRC_W-1:0]    h_a_source,
   input  logic [ADDR_W-1:0]   h_a_address,
   input  logic [MASK_W-1:0]   h_a_mask,
   input  logic [DATA_W-1:0]   h_a_data,
   // Host D
   output logic                h_d_valid,
   input  logic                h_d_ready,
   output logic [OPCODE_W-1:0] h_d_opcode,
   output logic [SIZE_W-1:0]   h_d_size,
   output logic [SRC_W-1:0]    h_d_source,
   output logic                h_d_denied,
   output logic [DATA_W-1:0]   h_d_data,
   // Device A
   output logic                dev_a_valid,
   input  logic                dev_a_ready,
   output logic [OPCODE_W-1:0] dev_a_opcode,
   output logic [PARAM_W-1:0]  dev_a_param,
   output logic [SIZE_W-1:0]   dev_a_size,
   output logic [SRC_W-1:0]    dev_a_source,
   output logic [ADDR_W-1:0]   dev_a_address,
   output logic [MASK_W-1:0]   dev_a_mask,
   output logic [DATA_W-1:0]   dev_a_data,
   // Device D
   input  logic                dev_d_valid,
   output logic                dev_d_ready,
   input  logic [OPCODE_W-1:0] dev_d_opcode,
   input  logic [SIZE_W-1:0]   dev_d_size,
   input  logic [SRC_W-1:0]    dev_d_source,
   input  logic                dev_d_denied,
   input  logic [DATA_W-1:0]   dev_d_data,
   // Error responder A
   output logic                err_a_valid,
   input  logic                err_a_ready,
   output logic [OPCODE_W-1:0] err_a_opcode,
   output logic [PARAM_W-1:0]  err_a_param,
   output logic [SIZE_W-1:0]   err_a_size,
   output logic [SRC_W-1:0]    err_a_source,
   output logic [ADDR_W-1:0]   err_a_address,
   output logic [MASK_W-1:0]   err_a_mask,
   output logic [DATA_W-1:0]   err_a_data,
   // Error responder D
   input  logic                err_d_valid,
   output logic                err_d_ready,
   input  logic [OPCODE_W-1:0] err_d_opcode,
   input  logic [SIZE_W-1:0]   err_d_size,
   input  logic [SRC_W-1:0]    err_d_source,
   input  logic                err_d_denied,
   input  logic [DATA_W-1:0]   err_d_data,
   // Miss log
   output logic                err_log_valid,
   output logic [ADDR_W-1:0]   err_log_addr,
   input  logic                err_log_clr
);

   logic             hit;
   tgt_e             dec_tgt;
   logic             allow;
   logic             busy;
   logic [CNT_W-1:0] cnt;
   tgt_e             tgt;
   logic             a_fire;
   logic             d_fire;

   assign hit     = ((h_a_address & DEV_MASK) == DEV_BASE);
   assign dec_tgt = hit ? TgtDev : TgtErr;

   // A channel: fields fan out unmodified, only valid is steered
   assign dev_a_valid = h_a_valid & allow & hit;
   assign err_a_valid = h_a_valid & allow & ~hit;
   assign h_a_ready   = allow & (hit ? dev_a_ready : err_a_ready);

   assign dev_a_opcode  = h_a_opcode;
   assign dev_a_param   = h_a_param;
   assign dev_a_size    = h_a_size;
   assign dev_a_source  = h_a_source;
   assign dev_a_address = h_a_address;
   assign dev_a_mask    = h_a_mask;
   assign dev_a_data    = h_a_data;

   assign err_a_opcode  = h_a_opcode;
   assign err_a_param   = h_a_param;
   assign err_a_size    = h_a_size;
   assign err_a_source  = h_a_source;
   assign err_a_address = h_a_address;
   assign err_a_mask    = h_a_mask;
   assign err_a_data    = h_a_data;

   // D channel: only the owning port is listened to, and only while busy, so
   // stray responses from the other port (or at idle) are never accepted.
   assign dev_d_ready = busy & (tgt == TgtDev) & h_d_ready;
   assign err_d_ready = busy & (tgt == TgtErr) & h_d_ready;

   always_comb begin
      h_d_valid  = 1'b0;
      h_d_opcode = dev_d_opcode;
      h_d_size   = dev_d_size;
      h_d_source = dev_d_source;
      h_d_denied = dev_d_denied;
      h_d_data   = dev_d_data;
      if (tgt == TgtDev) begin
         h_d_valid = busy & dev_d_valid;
      end else begin
         h_d_valid  = busy & err_d_valid;
         h_d_opcode = err_d_opcode;
         h_d_size   = err_d_size;
         h_d_source = err_d_source;
         h_d_denied = err_d_denied;
         h_d_data   = err_d_data;
      end
   end

   assign a_fire = h_a_valid & h_a_ready;
   assign d_fire = h_d_valid & h_d_ready;

   tl_addr_decode_tracker #(
      .MAX_OUT (MAX_OUT)
   ) u_tracker (
      .clock   (clock),
      .reset_n (reset_n),
      .dec_tgt (dec_tgt),
      .a_fire  (a_fire),
      .d_fire  (d_fire),
      .cnt     (cnt),
      .tgt     (tgt),
      .allow   (allow),
      .busy    (busy)
   );

`ifdef TL_ADDR_DECODE_ERR_LOG_EN
   logic              log_valid_q, log_valid_d;
   logic [ADDR_W-1:0] log_addr_q, log_addr_d;

   // Clear takes priority over a capture in the same cycle
   always_comb begin
      log_valid_d = log_valid_q;
      log_addr_d  = log_addr_q;
      if (err_log_clr) begin
         log_valid_d = 1'b0;
         log_addr_d  = '0;
      end else if (a_fire && !hit && !log_valid_q) begin
         log_valid_d = 1'b1;
         log_addr_d  = h_a_address;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         log_valid_q <= 1'b0;
         log_addr_q  <= '0;
      end else begin
         log_valid_q <= log_valid_d;
         log_addr_q  <= log_addr_d;
      end
   end

   assign err_log_valid = log_valid_q;
   assign err_log_addr  = log_addr_q;
`else
   logic unused_log_clr;
   assign unused_log_clr = err_log_clr;
   assign err_log_valid  = 1'b0;
   assign err_log_addr   = '0;
`endif

endmodule

// File: tb/tb_tl_addr_decode.sv
// Self-checking bench for tl_addr_decode: directed scenarios followed by a
// randomized phase checked against a queue-based model of outstanding
// requests.
module tb_tl_addr_decode;
   import tl_ul_pkg::*;

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned SRC_W   = 4;
   localparam int unsigned MAX_OUT = 4;
`ifdef TL_ADDR_DECODE_ERR_LOG_EN
   localparam bit LogEn = 1'b1;
`else
   localparam bit LogEn = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic              h_a_valid, h_a_ready;
   logic [2:0]        h_a_opcode, h_a_param;
   logic [1:0]        h_a_size;
   logic [SRC_W-1:0]  h_a_source;
   logic [ADDR_W-1:0] h_a_address;
   logic [3:0]        h_a_mask;
   logic [31:0]       h_a_data;
   logic              h_d_valid, h_d_ready, h_d_denied;
   logic [2:0]        h_d_opcode;
   logic [1:0]        h_d_size;
   logic [SRC_W-1:0]  h_d_source;
   logic [31:0]       h_d_data;
   logic              dev_a_valid, dev_a_ready, err_a_valid, err_a_ready;
   logic [2:0]        dev_a_opcode, dev_a_param, err_a_opcode, err_a_param;
   logic [1:0]        dev_a_size, err_a_size;
   logic [SRC_W-1:0]  dev_a_source, err_a_source;
   logic [ADDR_W-1:0] dev_a_address, err_a_address;
   logic [3:0]        dev_a_mask, err_a_mask;
   logic [31:0]       dev_a_data, err_a_data;
   logic              dev_d_valid, dev_d_ready, dev_d_denied;
   logic              err_d_valid, err_d_ready, err_d_denied;
   logic [2:0]        dev_d_opcode, err_d_opcode;
   logic [1:0]        dev_d_size, err_d_size;
   logic [SRC_W-1:0]  dev_d_source, err_d_source;
   logic [31:0]       dev_d_data, err_d_data;
   logic              err_log_valid, err_log_clr;
   logic [ADDR_W-1:0] err_log_addr;

   tl_addr_decode #(
      .ADDR_W   (ADDR_W),
      .SRC_W    (SRC_W),
      .MAX_OUT  (MAX_OUT),
      .DEV_BASE (14'h0000),
      .DEV_MASK (14'h2000)
   ) dut (
      .clock (clock), .reset_n (reset_n),
      .h_a_valid (h_a_valid), .h_a_ready (h_a_ready), .h_a_opcode (h_a_opcode),
      .h_a_param (h_a_param), .h_a_size (h_a_size), .h_a_source (h_a_source),
      .h_a_address (h_a_address), .h_a_mask (h_a_mask), .h_a_data (h_a_data),
      .h_d_valid (h_d_valid), .h_d_ready (h_d_ready), .h_d_opcode (h_d_opcode),
      .h_d_size (h_d_size), .h_d_source (h_d_source), .h_d_denied (h_d_denied),
      .h_d_data (h_d_data),
      .dev_a_valid (dev_a_valid), .dev_a_ready (dev_a_ready),
      .dev_a_opcode (dev_a_opcode), .dev_a_param (dev_a_param),
      .dev_a_size (dev_a_size), .dev_a_source (dev_a_source),
      .dev_a_address (dev_a_address), .dev_a_mask (dev_a_mask),
      .dev_a_data (dev_a_data),
      .dev_d_valid (dev_d_valid), .dev_d_ready (dev_d_ready),
      .dev_d_opcode (dev_d_opcode), .dev_d_size (dev_d_size),
      .dev_d_source (dev_d_source), .dev_d_denied (dev_d_denied),
      .dev_d_data (dev_d_data),
      .err_a_valid (err_a_valid), .err_a_ready (err_a_ready),
      .err_a_opcode (err_a_opcode), .err_a_param (err_a_param),
      .err_a_size (err_a_size), .err_a_source (err_a_source),
      .err_a_address (err_a_address), .err_a_mask (err_a_mask),
      .err_a_data (err_a_data),
      .err_d_valid (err_d_valid), .err_d_ready (err_d_ready),
      .err_d_opcode (err_d_opcode), .err_d_size (err_d_size),
      .err_d_source (err_d_source), .err_d_denied (err_d_denied),
      .err_d_data (err_d_data),
      .err_log_valid (err_log_valid), .err_log_addr (err_log_addr),
      .err_log_clr (err_log_clr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      h_a_valid = 0; h_a_opcode = Get; h_a_param = 0; h_a_size = 2; h_a_source = 0;
      h_a_address = 0; h_a_mask = 4'hf; h_a_data = 0; h_d_ready = 1;
      dev_a_ready = 0; err_a_ready = 0; err_log_clr = 0;
      dev_d_valid = 0; dev_d_opcode = AccessAck; dev_d_size = 2; dev_d_source = 0;
      dev_d_denied = 0; dev_d_data = 0;
      err_d_valid = 0; err_d_opcode = AccessAck; err_d_size = 2; err_d_source = 0;
      err_d_denied = 1; err_d_data = 0;
   endtask

   task automatic send_a(input logic [2:0] op, input logic [ADDR_W-1:0] addr);
      h_a_valid = 1; h_a_opcode = op; h_a_address = addr;
      dev_a_ready = 1; err_a_ready = 1;
   endtask

   // Model of outstanding requests: one entry per request, oldest first
   int unsigned q[$];
   bit          m_log_valid;
   int unsigned m_log_addr;

   initial begin
      idle();
      reset_n = 0;
      #3;
      chk("rst_h_d_valid", h_d_valid, 0);
      chk("rst_dev_a_valid", dev_a_valid, 0);
      chk("rst_err_a_valid", err_a_valid, 0);
      chk("rst_log_valid", err_log_valid, 0);
      chk("rst_log_addr", err_log_addr, 0);
      chk("rst_cnt", dut.u_tracker.cnt_q, 0);
      tick(); tick();
      reset_n = 1;
      tick();

      // Dev Get and AccessAckData return
      send_a(Get, 14'h0100); h_a_source = 4'h5;
      #1;
      chk("get_dev_a_valid", dev_a_valid, 1);
      chk("get_err_a_valid", err_a_valid, 0);
      chk("get_h_a_ready", h_a_ready, 1);
      chk("get_dev_a_addr", dev_a_address, 32'h0100);
      chk("get_dev_a_src", dev_a_source, 5);
      tick();
      idle();
      chk("get_cnt1", dut.u_tracker.cnt_q, 1);
      dev_d_valid = 1; dev_d_opcode = AccessAckData; dev_d_data = 32'hDEADBEEF;
      #1;
      chk("get_h_d_valid", h_d_valid, 1);
      chk("get_h_d_data", h_d_data, 32'hDEADBEEF);
      chk("get_h_d_opcode", h_d_opcode, AccessAckData);
      tick();
      idle();
      chk("get_cnt0", dut.u_tracker.cnt_q, 0);

      // Miss routed to error responder, denied response
      send_a(Get, 14'h2004);
      #1;
      chk("miss_err_a_valid", err_a_valid, 1);
      chk("miss_dev_a_valid", dev_a_valid, 0);
      tick();
      idle();
      chk("miss_tgt", dut.u_tracker.tgt_q, 1);
      chk("miss_log_valid", err_log_valid, LogEn ? 1 : 0);
      chk("miss_log_addr", err_log_addr, LogEn ? 32'h2004 : 0);
      err_d_valid = 1; err_d_denied = 1;
      #1;
      chk("miss_h_d_valid", h_d_valid, 1);
      chk("miss_h_d_denied", h_d_denied, 1);
      chk("miss_dev_d_ready", dev_d_ready, 0);
      tick();
      idle();

      // Target switch waits for the outstanding dev response
      send_a(Get, 14'h0100);
      tick();
      send_a(Get, 14'h2008);
      #1;
      chk("sw_stall_ready", h_a_ready, 0);
      chk("sw_stall_err_valid", err_a_valid, 0);
      tick();
      chk("sw_stall_ready2", h_a_ready, 0);
      dev_d_valid = 1;
      #1;
      chk("sw_dfire_ready", h_a_ready, 0);
      tick();
      dev_d_valid = 0;
      chk("sw_cnt0", dut.u_tracker.cnt_q, 0);
      chk("sw_accept_ready", h_a_ready, 1);
      chk("sw_accept_err_valid", err_a_valid, 1);
      tick();
      idle();
      chk("sw_log_sticky", err_log_addr, LogEn ? 32'h2004 : 0);
      err_d_valid = 1;
      tick();
      idle();
      err_log_clr = 1;
      tick();
      idle();
      chk("clr_log_valid", err_log_valid, 0);
      chk("clr_log_addr", err_log_addr, 0);

      // Back-to-back dev Puts up to the outstanding limit
      for (int i = 0; i < 4; i++) begin
         send_a(PutFull, 14'h0010);
         #1;
         chk("put_ready", h_a_ready, 1);
         tick();
      end
      chk("put_cnt4", dut.u_tracker.cnt_q, 4);
      chk("put5_ready", h_a_ready, 0);
      chk("put5_dev_valid", dev_a_valid, 0);
      dev_d_valid = 1;
      tick();
      chk("put_cnt3", dut.u_tracker.cnt_q, 3);
      chk("put_dfire_a_ready", h_a_ready, 1);
      tick();
      chk("put_hold_cnt", dut.u_tracker.cnt_q, 3);
      dev_d_valid = 0;
      tick();
      chk("put_refill_cnt", dut.u_tracker.cnt_q, 4);
      idle();
      dev_d_valid = 1;
      repeat (4) tick();
      idle();
      chk("put_drain_cnt", dut.u_tracker.cnt_q, 0);

      // Spurious error response while idle
      err_d_valid = 1;
      #1;
      chk("spur_err_d_ready", err_d_ready, 0);
      chk("spur_h_d_valid", h_d_valid, 0);
      tick();
      chk("spur_cnt", dut.u_tracker.cnt_q, 0);
      idle();

      // Asynchronous reset with three error requests in flight
      for (int i = 0; i < 3; i++) begin
         send_a(Get, 14'h2100);
         tick();
      end
      idle();
      chk("arst_cnt3", dut.u_tracker.cnt_q, 3);
      err_d_valid = 1; h_d_ready = 0;
      #2;
      reset_n = 0;
      #1;
      chk("arst_cnt", dut.u_tracker.cnt_q, 0);
      chk("arst_tgt", dut.u_tracker.tgt_q, 0);
      chk("arst_log_valid", err_log_valid, 0);
      chk("arst_h_d_valid", h_d_valid, 0);
      tick();
      idle();
      reset_n = 1;
      tick();

      // Randomized traffic against the queue model
      m_log_valid = 0;
      m_log_addr  = 0;
      for (int n = 0; n < 600; n++) begin
         bit          hit, allowed, e_ready, e_dvalid, a_fire, d_fire, dev_owner;
         int unsigned tgt;
         h_a_valid   = $urandom_range(0, 3) != 0;
         h_a_address = ADDR_W'($urandom);
         h_a_opcode  = ($urandom_range(0, 2) == 0) ? PutFull : Get;
         h_a_source  = SRC_W'($urandom);
         h_a_data    = $urandom;
         dev_a_ready = $urandom_range(0, 3) != 0;
         err_a_ready = $urandom_range(0, 3) != 0;
         dev_d_valid = $urandom_range(0, 2) == 0;
         err_d_valid = $urandom_range(0, 2) == 0;
         dev_d_data  = $urandom;
         err_d_data  = $urandom;
         h_d_ready   = $urandom_range(0, 3) != 0;
         err_log_clr = $urandom_range(0, 15) == 0;
         #1;
         hit       = (h_a_address < 14'h2000);
         tgt       = hit ? 0 : 1;
         allowed   = (q.size() < MAX_OUT) && (q.size() == 0 || q[0] == tgt);
         e_ready   = allowed && (hit ? dev_a_ready : err_a_ready);
         dev_owner = (q.size() > 0) && (q[0] == 0);
         e_dvalid  = (q.size() > 0) && (dev_owner ? dev_d_valid : err_d_valid);
         chk("rnd_cnt", dut.u_tracker.cnt_q, q.size());
         chk("rnd_h_a_ready", h_a_ready, e_ready);
         chk("rnd_dev_a_valid", dev_a_valid, h_a_valid && allowed && hit);
         chk("rnd_err_a_valid", err_a_valid, h_a_valid && allowed && !hit);
         chk("rnd_h_d_valid", h_d_valid, e_dvalid);
         chk("rnd_dev_d_ready", dev_d_ready, dev_owner && h_d_ready);
         chk("rnd_err_d_ready", err_d_ready, (q.size() > 0) && !dev_owner && h_d_ready);
         if (e_dvalid) chk("rnd_h_d_data", h_d_data, dev_owner ? dev_d_data : err_d_data);
         chk("rnd_a_data", hit ? dev_a_data : err_a_data, h_a_data);
         chk("rnd_log_valid", err_log_valid, LogEn ? m_log_valid : 0);
         chk("rnd_log_addr", err_log_addr, LogEn ? m_log_addr : 0);
         a_fire = h_a_valid && e_ready;
         d_fire = e_dvalid && h_d_ready;
         tick();
         if (d_fire) void'(q.pop_front());
         if (a_fire) q.push_back(tgt);
         if (err_log_clr) begin
            m_log_valid = 0;
            m_log_addr  = 0;
         end else if (a_fire && !hit && !m_log_valid) begin
            m_log_valid = 1;
            m_log_addr  = h_a_address;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
